autoconv_sequencer: RTL and testbench



---
 rtl/autoconv_sequencer.sv | 133 +++++++++++++
 tb/tb_autoconv_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/autoconv_sequencer.sv
// Control sequencer for the audio self-convolution datapath: walks lag m and product index n,
// drives sample-RAM reads, MAC strobes and output-RAM writes. Optional macro: AUTOCONV_HALF_EN.
module autoconv_sequencer #(
  parameter int N  = 480,
  parameter int AW = 9,
  parameter int LW = 10
) (
  input  logic          Clk,
  input  logic          Reset_h,
  input  logic          blk_ready,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic [AW-1:0] rd_a_addr,
  output logic [AW-1:0] rd_b_addr,
  output logic          rd_vld,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_dbl,
  output logic          out_we,
  output logic [LW-1:0] out_addr,
  output logic [2:0]    dbgState
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [LW-1:0] NM1   = LW'(N - 1);
  localparam logic [LW-1:0] MLAST = LW'(2 * N - 2);

  state_t        state, stateNxt;
  logic [LW-1:0] m, mNxt;
  logic [AW-1:0] n, nNxt;
  logic [LW-1:0] nLo, nHi;
  logic [AW-1:0] diffA;
  logic          lastN;

  // Product index bounds for the current lag; m-n is formed at lag width then truncated.
  assign nLo = (m > NM1) ? (m - NM1) : '0;
`ifdef AUTOCONV_HALF_EN
  logic [LW-1:0] mHalf;
  assign mHalf = {1'b0, m[LW-1:1]};
  assign nHi   = (mHalf < NM1) ? mHalf : NM1;
`else
  assign nHi = (m < NM1) ? m : NM1;
`endif
  assign diffA = AW'(m - LW'(n));
  assign lastN = (LW'(n) == nHi);

  always_comb begin
    stateNxt = state;
    mNxt     = m;
    nNxt     = n;
    rd_vld   = 1'b0;
    mac_clr  = 1'b0;
    out_we   = 1'b0;
    case (state)
      IDLE: begin
        if (blk_ready) begin
          stateNxt = INIT;
          mNxt     = '0;
        end
      end
      INIT: begin
        mac_clr  = 1'b1;
        nNxt     = AW'(nLo);
        stateNxt = RUN;
      end
      RUN: begin
        rd_vld = 1'b1;
        if (lastN) stateNxt = DRAIN;
        else       nNxt     = n + 1'b1;
      end
      DRAIN: stateNxt = STORE;
      STORE: begin
        out_we = 1'b1;
        if (m == MLAST) begin
          stateNxt = DONE;
        end else begin
          mNxt     = m + 1'b1;
          stateNxt = INIT;
        end
      end
      DONE: begin
        stateNxt = IDLE;
        mNxt     = '0;
        nNxt     = '0;
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset_h) begin
      state  <= IDLE;
      m      <= '0;
      n      <= '0;
      mac_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state  <= stateNxt;
      m      <= mNxt;
      n      <= nNxt;
      // RAM read latency is one cycle, so accumulate the cycle after each read.
      mac_en <= rd_vld;
      ovf    <= ovf | (blk_ready && (state != IDLE));
    end
  end

`ifdef AUTOCONV_HALF_EN
  // Off-diagonal products stand for both x[n]x[m-n] and x[m-n]x[n].
  always_ff @(posedge Clk) begin
    if (Reset_h) mac_dbl <= 1'b0;
    else         mac_dbl <= rd_vld && (diffA != n);
  end
`else
  assign mac_dbl = 1'b0;
`endif

  assign rd_a_addr = rd_vld ? n : '0;
  assign rd_b_addr = rd_vld ? diffA : '0;
  assign out_addr  = out_we ? m : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbgState  = state;

endmodule

// File: tb/tb_autoconv_sequencer.sv
// Scoreboard bench for autoconv_sequencer at N=4 with x={1,2,3,4}; covers the
// default and AUTOCONV_HALF_EN builds.
module tb_autoconv_sequencer;
  localparam int N  = 4;
  localparam int AW = 9;
  localparam int LW = 10;
  localparam int W  = 34;

`ifdef AUTOCONV_HALF_EN
  localparam int EXP_DONE = 32;
  int expCnt[7] = '{1, 1, 2, 2, 2, 1, 1};
`else
  localparam int EXP_DONE = 38;
  int expCnt[7] = '{1, 2, 3, 4, 3, 2, 1};
`endif
  int expVal[7] = '{1, 4, 10, 20, 25, 24, 16};
  int x[4] = '{1, 2, 3, 4};

  logic          Clk = 1'b0;
  logic          Reset_h;
  logic          blk_ready;
  logic          busy, done, ovf;
  logic [AW-1:0] rd_a_addr, rd_b_addr;
  logic          rd_vld, mac_clr, mac_en, mac_dbl, out_we;
  logic [LW-1:0] out_addr;
  logic [2:0]    dbgState;

  autoconv_sequencer #(.N(N), .AW(AW), .LW(LW)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .blk_ready(blk_ready),
    .busy(busy), .done(done), .ovf(ovf),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_vld(rd_vld),
    .mac_clr(mac_clr), .mac_en(mac_en), .mac_dbl(mac_dbl),
    .out_we(out_we), .out_addr(out_addr), .dbgState(dbgState)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0]      exp_q[$];
  logic [2*AW-1:0]   pairs_q[$];
  logic              capPairs = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor with sample-RAM/MAC model
  int   acc = 0, pend = 0, lagCnt = 0, lagIdx = 0, busyCnt = 0, doneSeen = 0;
  logic prevVld = 1'b0, prevClr = 1'b0, prevOffDiag = 1'b0;
  logic [W-1:0] e;

  always @(negedge Clk) begin
    if (Reset_h) begin
      prevVld = 1'b0; prevClr = 1'b0; lagCnt = 0; lagIdx = 0; busyCnt = 0;
    end else begin
      busyCnt = busy ? busyCnt + 1 : 0;
      if (!busy) begin lagCnt = 0; lagIdx = 0; end
      check("mac_en_lag", {63'd0, mac_en}, {63'd0, prevVld});
      if (mac_en) begin
`ifdef AUTOCONV_HALF_EN
        check("mac_dbl", {63'd0, mac_dbl}, {63'd0, prevOffDiag});
`else
        check("mac_dbl", {63'd0, mac_dbl}, 64'd0);
`endif
      end
      if (rd_vld && !prevVld) check("clr_lead", {63'd0, prevClr}, 64'd1);
      if (out_we) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL store_unexpected: got addr %0d expected no write", out_addr);
        end else begin
          e = exp_q.pop_front();
          check("store", {30'd0, out_addr, acc[15:0], lagCnt[7:0]}, {30'd0, e});
        end
        lagCnt = 0;
        lagIdx = lagIdx + 1;
      end
      if (done) begin
        doneSeen++;
        check("done_cycle", busyCnt, EXP_DONE);
      end
      if (mac_en) acc = acc + (mac_dbl ? 2 : 1) * pend;
      if (mac_clr) acc = 0;
      if (rd_vld) begin
        check("rd_range", {63'd0, (rd_a_addr < N) && (rd_b_addr < N)}, 64'd1);
        pend = (rd_a_addr < N && rd_b_addr < N) ? x[rd_a_addr] * x[rd_b_addr] : 0;
        lagCnt++;
        prevOffDiag = (rd_a_addr != rd_b_addr);
        if (capPairs && lagIdx == 5) pairs_q.push_back({rd_a_addr, rd_b_addr});
      end
      prevVld = rd_vld;
      prevClr = mac_clr;
    end
  end

  // driver tasks
  task automatic tick(input int k);
    repeat (k) @(posedge Clk);
    #1;
  endtask

  task automatic sampleNeg();
    @(negedge Clk);
    #1;
  endtask

  task automatic pushBlock(input int lags);
    for (int i = 0; i < lags; i++)
      exp_q.push_back({LW'(i), 16'(expVal[i]), 8'(expCnt[i])});
  endtask

  task automatic waitDone(input int target, input int budget);
    int c = 0;
    while (doneSeen < target && c < budget) begin
      sampleNeg();
      c++;
    end
    if (doneSeen < target) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: got %0d done pulses expected %0d", doneSeen, target);
    end
  endtask

  logic [2*AW-1:0] pr;
  int savedDone;
  int c2;

  initial begin
    Reset_h = 1'b1;
    blk_ready = 1'b0;
    tick(3);
    Reset_h = 1'b0;
    sampleNeg();
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_ovf",   {63'd0, ovf}, 64'd0);
    check("rst_strb",  {60'd0, rd_vld, mac_clr, mac_en, out_we}, 64'd0);
    check("rst_dbl",   {63'd0, mac_dbl}, 64'd0);
    check("rst_addr",  {36'd0, rd_a_addr, rd_b_addr, out_addr}, 64'd0);
    check("rst_state", {61'd0, dbgState}, 64'd0);

    // single block, blk_ready pulsed one cycle
    pushBlock(7);
    capPairs = 1'b1;
    tick(1);
    blk_ready = 1'b1;
    tick(1);
    blk_ready = 1'b0;
    sampleNeg();
    check("busy_rise", {63'd0, busy}, 64'd1);
    waitDone(1, 100);
    capPairs = 1'b0;
    tick(2);
    check("blk1_drained", exp_q.size(), 0);
    check("blk1_ovf", {63'd0, ovf}, 64'd0);
    check("blk1_idle", {63'd0, busy}, 64'd0);
`ifdef AUTOCONV_HALF_EN
    check("m5_pair_cnt", pairs_q.size(), 1);
    if (pairs_q.size() > 0) begin pr = pairs_q.pop_front(); check("m5_pair0", pr, {9'd2, 9'd3}); end
`else
    check("m5_pair_cnt", pairs_q.size(), 2);
    if (pairs_q.size() > 0) begin pr = pairs_q.pop_front(); check("m5_pair0", pr, {9'd2, 9'd3}); end
    if (pairs_q.size() > 0) begin pr = pairs_q.pop_front(); check("m5_pair1", pr, {9'd3, 9'd2}); end
`endif

    // reset mid-block while running lag 3
    pushBlock(3);
    blk_ready = 1'b1;
    tick(1);
    blk_ready = 1'b0;
    c2 = 0;
    while (!(lagIdx == 3 && rd_vld) && c2 < 100) begin
      sampleNeg();
      c2++;
    end
    check("reach_m3", {63'd0, (lagIdx == 3 && rd_vld)}, 64'd1);
    savedDone = doneSeen;
    @(posedge Clk); #1;
    Reset_h = 1'b1;
    tick(1);
    Reset_h = 1'b0;
    sampleNeg();
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_strb", {61'd0, rd_vld, mac_en, out_we}, 64'd0);
    tick(20);
    check("abort_nodone", doneSeen, savedDone);
    check("abort_flush", exp_q.size(), 0);

    // fresh block after abort restarts at lag 0
    pushBlock(7);
    blk_ready = 1'b1;
    tick(1);
    blk_ready = 1'b0;
    waitDone(savedDone + 1, 100);
    tick(2);
    check("restart_drained", exp_q.size(), 0);

    // blk_ready held high across two blocks
    pushBlock(7);
    pushBlock(7);
    blk_ready = 1'b1;
    tick(1);
    sampleNeg();
    check("held_busy1", {63'd0, busy}, 64'd1);
    check("held_ovf_first", {63'd0, ovf}, 64'd0);
    sampleNeg();
    check("held_ovf_second", {63'd0, ovf}, 64'd1);
    savedDone = doneSeen;
    waitDone(savedDone + 1, 100);
    sampleNeg();
    check("held_gap_idle", {63'd0, busy}, 64'd0);
    sampleNeg();
    check("held_restart", {63'd0, busy}, 64'd1);
    @(posedge Clk); #1;
    blk_ready = 1'b0;
    waitDone(savedDone + 2, 100);
    tick(2);
    check("held_ovf_sticky", {63'd0, ovf}, 64'd1);
    check("held_drained", exp_q.size(), 0);

    // reset clears ovf
    Reset_h = 1'b1;
    tick(1);
    Reset_h = 1'b0;
    sampleNeg();
    check("ovf_cleared", {63'd0, ovf}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
